instr_realigner: RTL and testbench
==================================

Name: instr_realigner

Overview:
Fetch-side consumer of the compressed-instruction stream. It takes 32-bit fetch words with their word address and emits one instruction per handshake to decode: a 16-bit compressed instruction, or a 32-bit instruction that may straddle two fetch words. It holds at most one pending halfword. It applies back-pressure to fetch while emitting a buffered compressed halfword or while completing a spanning instruction.

Parameters:
XLEN, 32, width of the PC and fetch-word address.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous flush (branch/trap redirect); discards buffered halfword
fetch_valid  in  1  fetch word available
fetch_data  in  32  fetch word; bits [15:0] = lower halfword
fetch_pc  in  XLEN  address of first useful halfword; bit1=1 only on first word after redirect
fetch_ready  out  1  fetch word consumed this cycle when high with fetch_valid
instr_valid  out  1  instruction presented to decode
instr  out  32  instruction; upper 16 bits zero when compressed
instr_pc  out  XLEN  instruction address
instr_compressed  out  1  instr is 16-bit (low bits != 2'b11)
instr_ready  in  1  decode accepts instr

Behaviour:
- Registers:
  - state: EMPTY / BUF.
  - hbuf[15:0]: buffered halfword.
  - hbuf_pc[XLEN-1:0]: address of hbuf.
- Reset values: state=EMPTY, hbuf=0, hbuf_pc=0.
- While reset is high, instr_valid=0 and fetch_ready=0.
- Output path is combinational from state and fetch inputs, so zero-cycle latency. An instruction transfers when instr_valid & instr_ready.
- Halfword classification: compressed iff hw[1:0] != 2'b11.
- EMPTY, fetch_pc[1]=0, word w:
  - w[1:0] != 11: emit {16'h0, w[15:0]} @fetch_pc, compressed. On transfer: consume word, hbuf=w[31:16], hbuf_pc=fetch_pc+2, go BUF.
  - w[1:0] == 11: emit w @fetch_pc, 32-bit. On transfer: consume word, stay EMPTY.
- EMPTY, fetch_pc[1]=1 (redirect into upper half; w[15:0] ignored):
  - w[17:16] != 11: emit {16'h0, w[31:16]} @fetch_pc, compressed. On transfer: consume, stay EMPTY.
  - Otherwise: instr_valid=0, fetch_ready=1 (no output needed). Consume word: hbuf=w[31:16], hbuf_pc=fetch_pc, go BUF.
- BUF, hbuf compressed:
  - Emit {16'h0, hbuf} @hbuf_pc, independent of fetch_valid; fetch_ready=0.
  - On transfer: go EMPTY.
- BUF, hbuf not compressed (spanning):
  - instr_valid = fetch_valid. Emit {w[15:0], hbuf} @hbuf_pc, 32-bit.
  - On transfer: consume word, hbuf=w[31:16], hbuf_pc=hbuf_pc+4, stay BUF.
- fetch_ready is high only in cycles where the word is consumed, per the rules above. The word is never consumed without a completed output transfer, except in the EMPTY/pc[1]=1/non-compressed case.
- Back-pressure: with instr_ready=0, no state change and outputs remain stable while inputs are stable.
- clear:
  - Highest priority over handshakes: state=EMPTY next cycle; hbuf and hbuf_pc retain their values (don't-care).
  - In the clear cycle, instr_valid=0 and fetch_ready=0.
  - The first word after clear may have fetch_pc[1]=1.
- Contiguity: fetch words between clears are consecutive words. The block does not check this.
- PC arithmetic is modulo 2^XLEN (wraps).

Optional Feature:
Macro: REALIGN_PERF_EN.
- Defined: adds output ports perf_compressed[31:0] and perf_spanning[31:0].
  - perf_compressed increments on each transfer with instr_compressed=1.
  - perf_spanning increments on each 32-bit transfer sourced from BUF.
  - Both wrap at 2^32 and reset to 0; clear does not affect them.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. EMPTY, word 0x00010001 @0x100, instr_ready=1 -> cycle0: instr 0x00000001 @0x100, compressed, fetch_ready=1; cycle1: instr 0x00000001 @0x102, compressed, fetch_ready=0; then EMPTY.
2. Span: word 0x00130001 @0x200, then 0x00010000 @0x204:
   - 0x00000001 @0x200.
   - 0x00000013 @0x202, 32-bit, second word consumed.
   - 0x00000001 @0x206, fetch_ready=0.
3. Aligned 32-bit word 0x00500093 @0x300 -> instr 0x00500093 @0x300, instr_compressed=0, fetch_ready=1, remains EMPTY.
4. Back-pressure in scenario 2 at @0x202 with instr_ready=0 for 3 cycles -> instr/instr_pc stable, fetch_ready=0, accepted on cycle 4.
5. clear while BUF holds spanning half, then word 0x0001ABCD @0x402 -> clear cycle instr_valid=0; next instr 0x00000001 @0x402, compressed.
6. reset asserted mid-BUF -> instr_valid=0 and fetch_ready=0 immediately; after release, word 0x00000013 @0x0 yields instr 0x00000013 @0x0.

Source files
------------

// File: rtl/instr_realigner.sv
// Realigns 32-bit fetch words into 16/32-bit instructions for decode.
// Holds at most one pending halfword. Optional macro: REALIGN_PERF_EN.
//
// Ports:
//   clk, reset        core clock, async active-high reset
//   clear             sync flush; drops any buffered halfword
//   fetch_valid/ready handshake for fetch words
//   fetch_data        fetch word, bits [15:0] = lower halfword
//   fetch_pc          address of first useful halfword
//   instr_valid/ready handshake toward decode
//   instr             instruction, upper half zero when compressed
//   instr_pc          instruction address
//   instr_compressed  instr is a 16-bit encoding
//   perf_compressed   (REALIGN_PERF_EN) compressed transfers
//   perf_spanning     (REALIGN_PERF_EN) 32-bit transfers sourced from hbuf

module instr_realigner #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            fetch_valid,
  input  logic [31:0]     fetch_data,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_ready,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_compressed,
  input  logic            instr_ready
`ifdef REALIGN_PERF_EN
  ,
  output logic [31:0]     perf_compressed,
  output logic [31:0]     perf_spanning
`endif
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_BUF   = 1'b1;

  localparam logic [XLEN-1:0] PC_STEP2 = XLEN'(2);
  localparam logic [XLEN-1:0] PC_STEP4 = XLEN'(4);

  logic            state;
  logic            state_d;
  logic [15:0]     hbuf;
  logic [15:0]     hbuf_d;
  logic [XLEN-1:0] hbuf_pc;
  logic [XLEN-1:0] hbuf_pc_d;

  logic [15:0] lo_hw;
  logic [15:0] hi_hw;
  logic        lo_c;
  logic        hi_c;
  logic        hb_c;
  logic        xfer;
  logic        consume;

  assign lo_hw = fetch_data[15:0];
  assign hi_hw = fetch_data[31:16];
  assign lo_c  = (lo_hw[1:0] != 2'b11);
  assign hi_c  = (hi_hw[1:0] != 2'b11);
  assign hb_c  = (hbuf[1:0] != 2'b11);

  assign xfer    = instr_valid & instr_ready;
  assign consume = fetch_valid & fetch_ready;

  // Output path: purely combinational, so
  // an instruction can leave in the cycle
  // its word arrives.
  always_comb begin
    fetch_ready      = 1'b0;
    instr_valid      = 1'b0;
    instr            = '0;
    instr_pc         = fetch_pc;
    instr_compressed = 1'b0;
    if (!reset && !clear) begin
      case (state)
        ST_EMPTY: begin
          if (fetch_valid) begin
            if (!fetch_pc[1]) begin
              instr_valid = 1'b1;
              instr_compressed = lo_c;
              if (lo_c) begin
                instr = {16'h0, lo_hw};
              end else begin
                instr = fetch_data;
              end
              fetch_ready = instr_ready;
            end else if (hi_c) begin
              instr_valid      = 1'b1;
              instr            = {16'h0, hi_hw};
              instr_compressed = 1'b1;
              fetch_ready      = instr_ready;
            end else begin
              // Redirect onto the first half of
              // a 32-bit op: just park it.
              fetch_ready = 1'b1;
            end
          end
        end
        ST_BUF: begin
          instr_pc = hbuf_pc;
          if (hb_c) begin
            instr_valid      = 1'b1;
            instr            = {16'h0, hbuf};
            instr_compressed = 1'b1;
          end else begin
            instr_valid = fetch_valid;
            instr       = {lo_hw, hbuf};
            fetch_ready = fetch_valid
                        & instr_ready;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state;
    hbuf_d    = hbuf;
    hbuf_pc_d = hbuf_pc;
    if (clear) begin
      state_d = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (consume) begin
            if (!fetch_pc[1]) begin
              if (lo_c) begin
                hbuf_d    = hi_hw;
                hbuf_pc_d = fetch_pc + PC_STEP2;
                state_d   = ST_BUF;
              end
            end else if (!hi_c) begin
              hbuf_d    = hi_hw;
              hbuf_pc_d = fetch_pc;
              state_d   = ST_BUF;
            end
          end
        end
        ST_BUF: begin
          if (hb_c) begin
            if (xfer) begin
              state_d = ST_EMPTY;
            end
          end else if (consume) begin
            // Upper half of the word becomes
            // the next pending halfword.
            hbuf_d    = hi_hw;
            hbuf_pc_d = hbuf_pc + PC_STEP4;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_EMPTY;
      hbuf    <= '0;
      hbuf_pc <= '0;
    end else begin
      state   <= state_d;
      hbuf    <= hbuf_d;
      hbuf_pc <= hbuf_pc_d;
    end
  end

`ifdef REALIGN_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_compressed <= '0;
      perf_spanning   <= '0;
    end else begin
      if (xfer && instr_compressed) begin
        perf_compressed <= perf_compressed + 32'd1;
      end
      if (xfer && !instr_compressed
          && (state == ST_BUF)) begin
        perf_spanning <= perf_spanning + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_realigner.sv
// Bench for instr_realigner: halfword-stream model
// plus directed cycle-level literal checks.

module tb_instr_realigner;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_compressed;
  logic        instr_ready;
`ifdef REALIGN_PERF_EN
  logic [31:0] perf_compressed;
  logic [31:0] perf_spanning;
`endif

  instr_realigner #(.XLEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .clear            (clear),
    .fetch_valid      (fetch_valid),
    .fetch_data       (fetch_data),
    .fetch_pc         (fetch_pc),
    .fetch_ready      (fetch_ready),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_compressed (instr_compressed),
    .instr_ready      (instr_ready)
`ifdef REALIGN_PERF_EN
    ,
    .perf_compressed  (perf_compressed),
    .perf_spanning    (perf_spanning)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // fetch-side stimulus queue
  logic [31:0] fq_d[$];
  logic [31:0] fq_p[$];
  // model: useful halfword stream
  logic [15:0] hq_w[$];
  logic [31:0] hq_p[$];
  // model: expected instruction stream
  logic [31:0] exp_i[$];
  logic [31:0] exp_p[$];
  logic        exp_c[$];

  // per-cycle log of the last run
  logic [31:0] lg_i[16];
  logic [31:0] lg_p[16];
  logic        lg_v[16];
  logic        lg_fr[16];
  logic        lg_c[16];

  function automatic logic [31:0] z(logic b);
    return {31'b0, b};
  endfunction

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic push_word(logic [31:0] d,
                           logic [31:0] p);
    fq_d.push_back(d);
    fq_p.push_back(p);
    if (p[1]) begin
      hq_w.push_back(d[31:16]);
      hq_p.push_back(p);
    end else begin
      hq_w.push_back(d[15:0]);
      hq_p.push_back(p);
      hq_w.push_back(d[31:16]);
      hq_p.push_back(p + 32'd2);
    end
  endtask

  // Split the halfword stream into
  // instructions; a trailing lone upper
  // half of a 32-bit op yields nothing.
  task automatic build();
    int i;
    i = 0;
    while (i < hq_w.size()) begin
      if (hq_w[i][1:0] != 2'b11) begin
        exp_i.push_back({16'h0, hq_w[i]});
        exp_p.push_back(hq_p[i]);
        exp_c.push_back(1'b1);
        i = i + 1;
      end else if (i + 1 < hq_w.size()) begin
        exp_i.push_back({hq_w[i+1], hq_w[i]});
        exp_p.push_back(hq_p[i]);
        exp_c.push_back(1'b0);
        i = i + 2;
      end else begin
        break;
      end
    end
    hq_w.delete();
    hq_p.delete();
  endtask

  task automatic flush();
    fq_d.delete();
    fq_p.delete();
    exp_i.delete();
    exp_p.delete();
    exp_c.delete();
  endtask

  task automatic run(int ncyc, int st_from,
                     int st_len, int clr_at);
    logic cons;
    for (int c = 0; c < ncyc; c++) begin
      instr_ready = !(c >= st_from &&
                      c < st_from + st_len);
      clear = (c == clr_at);
      if (fq_d.size() > 0) begin
        fetch_valid = 1'b1;
        fetch_data  = fq_d[0];
        fetch_pc    = fq_p[0];
      end else begin
        fetch_valid = 1'b0;
        fetch_data  = '0;
      end
      @(negedge clk);
      if (c < 16) begin
        lg_i[c]  = instr;
        lg_p[c]  = instr_pc;
        lg_v[c]  = instr_valid;
        lg_fr[c] = fetch_ready;
        lg_c[c]  = instr_compressed;
      end
      cons = fetch_valid && fetch_ready;
      @(posedge clk);
      #1;
      if (cons) begin
        void'(fq_d.pop_front());
        void'(fq_p.pop_front());
      end
    end
    clear       = 1'b0;
    fetch_valid = 1'b0;
    instr_ready = 1'b1;
    if (clr_at >= 0) begin
      flush();
    end else begin
      chk("drain_exp", exp_i.size(), 0);
      chk("drain_fetch", fq_d.size(), 0);
    end
  endtask

  // Stream compare against the model on
  // every transfer.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (exp_i.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_xfer: got %h@%h want none",
                 instr, instr_pc);
      end else begin
        chk("instr", instr, exp_i[0]);
        chk("pc", instr_pc, exp_p[0]);
        chk("compressed", z(instr_compressed),
            z(exp_c[0]));
        void'(exp_i.pop_front());
        void'(exp_p.pop_front());
        void'(exp_c.pop_front());
      end
    end
  end

  initial begin
    reset       = 1'b1;
    clear       = 1'b0;
    fetch_valid = 1'b1;
    fetch_data  = 32'h00010001;
    fetch_pc    = 32'h0;
    instr_ready = 1'b1;
    #2;
    chk("rst_valid", z(instr_valid), 0);
    chk("rst_fready", z(fetch_ready), 0);
    fetch_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("idle_valid", z(instr_valid), 0);

    // 1: compressed pair
    push_word(32'h00010001, 32'h100);
    build();
    chk("model_t1_pc", exp_p[1], 32'h102);
    run(3, -1, 0, -1);
    chk("t1_c0_i", lg_i[0], 32'h1);
    chk("t1_c0_p", lg_p[0], 32'h100);
    chk("t1_c0_fr", z(lg_fr[0]), 1);
    chk("t1_c0_c", z(lg_c[0]), 1);
    chk("t1_c1_p", lg_p[1], 32'h102);
    chk("t1_c1_fr", z(lg_fr[1]), 0);
    chk("t1_c2_v", z(lg_v[2]), 0);

    // 2: spanning instruction
    push_word(32'h00130001, 32'h200);
    push_word(32'h00010000, 32'h204);
    build();
    chk("model_t2_i", exp_i[1], 32'h13);
    chk("model_t2_p", exp_p[1], 32'h202);
    run(4, -1, 0, -1);
    chk("t2_c1_i", lg_i[1], 32'h13);
    chk("t2_c1_p", lg_p[1], 32'h202);
    chk("t2_c1_fr", z(lg_fr[1]), 1);
    chk("t2_c1_c", z(lg_c[1]), 0);
    chk("t2_c2_p", lg_p[2], 32'h206);
    chk("t2_c2_fr", z(lg_fr[2]), 0);
    chk("t2_c3_v", z(lg_v[3]), 0);

    // 3: aligned 32-bit
    push_word(32'h00500093, 32'h300);
    build();
    run(2, -1, 0, -1);
    chk("t3_i", lg_i[0], 32'h00500093);
    chk("t3_c", z(lg_c[0]), 0);
    chk("t3_fr", z(lg_fr[0]), 1);
    chk("t3_c1_v", z(lg_v[1]), 0);

    // 4: back-pressure on the span
    push_word(32'h00130001, 32'h200);
    push_word(32'h00010000, 32'h204);
    build();
    run(6, 1, 3, -1);
    for (int c = 1; c <= 3; c++) begin
      chk("t4_hold_i", lg_i[c], 32'h13);
      chk("t4_hold_p", lg_p[c], 32'h202);
      chk("t4_hold_fr", z(lg_fr[c]), 0);
      chk("t4_hold_v", z(lg_v[c]), 1);
    end
    chk("t4_c4_fr", z(lg_fr[4]), 1);
    chk("t4_c5_p", lg_p[5], 32'h206);

    // 5: clear with spanning half pending
    push_word(32'h00130001, 32'h400);
    push_word(32'h00010000, 32'h404);
    build();
    run(2, -1, 0, 1);
    chk("t5_clr_v", z(lg_v[1]), 0);
    chk("t5_clr_fr", z(lg_fr[1]), 0);
    push_word(32'h0001ABCD, 32'h402);
    build();
    run(2, -1, 0, -1);
    chk("t5_i", lg_i[0], 32'h1);
    chk("t5_p", lg_p[0], 32'h402);
    chk("t5_c", z(lg_c[0]), 1);
    chk("t5_c1_v", z(lg_v[1]), 0);

    // 7: redirect onto upper 32-bit half
    push_word(32'h00130000, 32'h602);
    push_word(32'h00000001, 32'h604);
    build();
    run(4, -1, 0, -1);
    chk("t7_c0_v", z(lg_v[0]), 0);
    chk("t7_c0_fr", z(lg_fr[0]), 1);
    chk("t7_c1_i", lg_i[1], 32'h00010013);
    chk("t7_c1_p", lg_p[1], 32'h602);
    chk("t7_c2_p", lg_p[2], 32'h606);

    // 8: PC wrap
    push_word(32'h00130001, 32'hFFFFFFFC);
    push_word(32'h00010000, 32'h0);
    build();
    run(4, -1, 0, -1);
    chk("t8_c1_p", lg_p[1], 32'hFFFFFFFE);
    chk("t8_c2_p", lg_p[2], 32'h2);

    // 6: reset mid-BUF
    push_word(32'h00010001, 32'h500);
    build();
    instr_ready = 1'b1;
    fetch_valid = 1'b1;
    fetch_data  = fq_d[0];
    fetch_pc    = fq_p[0];
    @(negedge clk);
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    #1;
    chk("t6_buf_v", z(instr_valid), 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_v", z(instr_valid), 0);
    chk("t6_rst_fr", z(fetch_ready), 0);
    flush();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_word(32'h00000013, 32'h0);
    build();
    run(2, -1, 0, -1);
    chk("t6_i", lg_i[0], 32'h13);
    chk("t6_p", lg_p[0], 32'h0);
    chk("t6_fr", z(lg_fr[0]), 1);
    chk("t6_c1_v", z(lg_v[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
